// File: rtl/ras.sv
// Return address stack: circular LIFO of {upc_index, target} entries
// with a checkpoint of ptr/count and restore on mispredict.
module ras #(
  parameter int RAS_DEPTH                  = 8,
  parameter int RAS_TARGET_WIDTH           = 12,
  parameter int UPPER_PC_TABLE_ENTRIES     = 4,
  parameter int LOG_RAS_DEPTH              = $clog2(RAS_DEPTH),
  parameter int LOG_UPPER_PC_TABLE_ENTRIES = $clog2(UPPER_PC_TABLE_ENTRIES)
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0]           push_target,
  input  logic [LOG_UPPER_PC_TABLE_ENTRIES-1:0] push_upc_index,
  input  logic                                  pop_valid,
  output logic                                  pop_target_valid,
  output logic [RAS_TARGET_WIDTH-1:0]           pop_target,
  output logic [LOG_UPPER_PC_TABLE_ENTRIES-1:0] pop_upc_index,
  output logic [LOG_RAS_DEPTH-1:0]              ckpt_ptr,
  output logic [LOG_RAS_DEPTH:0]                ckpt_count,
  input  logic                                  restore_valid,
  input  logic [LOG_RAS_DEPTH-1:0]              restore_ptr,
  input  logic [LOG_RAS_DEPTH:0]                restore_count
);

  localparam int EW = LOG_UPPER_PC_TABLE_ENTRIES + RAS_TARGET_WIDTH;
  localparam logic [LOG_RAS_DEPTH:0] DEPTH_C =
    (LOG_RAS_DEPTH+1)'(RAS_DEPTH);

  logic [EW-1:0]            stack_q [RAS_DEPTH];
  logic [LOG_RAS_DEPTH-1:0] ptr_q, ptr_d;
  logic [LOG_RAS_DEPTH:0]   cnt_q, cnt_d;
  logic                     wr_en;
  logic [LOG_RAS_DEPTH-1:0] wr_idx;
  logic                     empty, full;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == DEPTH_C);

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (restore_valid) begin
      ptr_d = restore_ptr;
      cnt_d = (restore_count > DEPTH_C) ? DEPTH_C : restore_count;
    end else if (push_valid && pop_valid && !empty) begin
      // call+return in one cycle replaces the top in place
      wr_en  = 1'b1;
      wr_idx = ptr_q;
    end else if (push_valid) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q + 1'b1;
      ptr_d  = ptr_q + 1'b1;
      cnt_d  = full ? cnt_q : cnt_q + 1'b1;
    end else if (pop_valid && !empty) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (wr_en) stack_q[wr_idx] <= {push_upc_index, push_target};
    end
  end

  assign {pop_upc_index, pop_target} = stack_q[ptr_q];
  assign pop_target_valid = !empty;
  assign ckpt_ptr   = ptr_q;
  assign ckpt_count = cnt_q;

endmodule

// File: tb/tb_ras.sv
// Directed self-checking bench for ras (DEPTH=8, 12-bit targets).
module tb_ras;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        push_valid = 1'b0;
  logic [11:0] push_target = '0;
  logic [1:0]  push_upc_index = '0;
  logic        pop_valid = 1'b0;
  logic        pop_target_valid;
  logic [11:0] pop_target;
  logic [1:0]  pop_upc_index;
  logic [2:0]  ckpt_ptr;
  logic [3:0]  ckpt_count;
  logic        restore_valid = 1'b0;
  logic [2:0]  restore_ptr = '0;
  logic [3:0]  restore_count = '0;

  int checks = 0;
  int errors = 0;

  ras dut (
    .CLK(CLK), .RST(RST),
    .push_valid(push_valid), .push_target(push_target),
    .push_upc_index(push_upc_index), .pop_valid(pop_valid),
    .pop_target_valid(pop_target_valid), .pop_target(pop_target),
    .pop_upc_index(pop_upc_index), .ckpt_ptr(ckpt_ptr),
    .ckpt_count(ckpt_count), .restore_valid(restore_valid),
    .restore_ptr(restore_ptr), .restore_count(restore_count)
  );

  always #5 CLK = ~CLK;

  task automatic drive(input logic pu, input logic [11:0] t,
                       input logic [1:0] ix, input logic po);
    push_valid = pu;
    push_target = t;
    push_upc_index = ix;
    pop_valid = po;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
    drive(1'b0, 12'h0, 2'd0, 1'b0);
    restore_valid = 1'b0;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (pop_target_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %0b want 0", pop_target_valid);
    end
    checks++;
    if (ckpt_ptr !== 3'd0) begin
      errors++; $display("FAIL reset_ptr got %0d want 0", ckpt_ptr);
    end
    checks++;
    if (ckpt_count !== 4'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", ckpt_count);
    end
    checks++;
    if (pop_target !== 12'h0 || pop_upc_index !== 2'd0) begin
      errors++;
      $display("FAIL reset_top got %h/%0d want 000/0", pop_target, pop_upc_index);
    end
  endtask

  task automatic test_lifo;
    logic [11:0] et [3];
    logic [1:0]  ei [3];
    et = '{12'h333, 12'h222, 12'h111};
    ei = '{2'd3, 2'd2, 2'd1};
    do_reset();
    drive(1'b1, 12'h111, 2'd1, 1'b0); tick();
    drive(1'b1, 12'h222, 2'd2, 1'b0); tick();
    drive(1'b1, 12'h333, 2'd3, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 12'h0, 2'd0, 1'b1);
      #1;
      checks++;
      if (pop_target_valid !== 1'b1 || pop_target !== et[i] ||
          pop_upc_index !== ei[i]) begin
        errors++;
        $display("FAIL lifo_pop%0d got %0b/%h/%0d want 1/%h/%0d", i,
                 pop_target_valid, pop_target, pop_upc_index, et[i], ei[i]);
      end
      tick();
    end
    checks++;
    if (pop_target_valid !== 1'b0 || ckpt_count !== 4'd0) begin
      errors++;
      $display("FAIL lifo_empty got %0b/%0d want 0/0",
               pop_target_valid, ckpt_count);
    end
    drive(1'b0, 12'h0, 2'd0, 1'b1); tick();
    checks++;
    if (ckpt_ptr !== 3'd0 || ckpt_count !== 4'd0) begin
      errors++;
      $display("FAIL lifo_underflow got ptr %0d cnt %0d want 0 0",
               ckpt_ptr, ckpt_count);
    end
  endtask

  task automatic test_overflow;
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 12'(i), 2'(i), 1'b0); tick();
    end
    checks++;
    if (ckpt_count !== 4'd8 || ckpt_ptr !== 3'd2) begin
      errors++;
      $display("FAIL ovf_state got ptr %0d cnt %0d want 2 8",
               ckpt_ptr, ckpt_count);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 12'h0, 2'd0, 1'b1);
      #1;
      checks++;
      if (pop_target_valid !== 1'b1 || pop_target !== 12'(10 - i)) begin
        errors++;
        $display("FAIL ovf_pop%0d got %0b/%h want 1/%h", i,
                 pop_target_valid, pop_target, 12'(10 - i));
      end
      tick();
    end
    drive(1'b0, 12'h0, 2'd0, 1'b1);
    #1;
    checks++;
    if (pop_target_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_pop9 got valid %0b want 0", pop_target_valid);
    end
    tick();
  endtask

  task automatic test_push_pop;
    do_reset();
    drive(1'b1, 12'h0AA, 2'd0, 1'b0); tick();
    drive(1'b1, 12'h0BB, 2'd1, 1'b1);
    #1;
    checks++;
    if (pop_target !== 12'h0AA) begin
      errors++; $display("FAIL pp_same_cycle got %h want 0aa", pop_target);
    end
    tick();
    checks++;
    if (pop_target !== 12'h0BB || pop_upc_index !== 2'd1 ||
        ckpt_count !== 4'd1 || ckpt_ptr !== 3'd1) begin
      errors++;
      $display("FAIL pp_after got %h/%0d ptr %0d cnt %0d want 0bb/1 1 1",
               pop_target, pop_upc_index, ckpt_ptr, ckpt_count);
    end
    do_reset();
    drive(1'b1, 12'h0BB, 2'd2, 1'b1); tick();
    checks++;
    if (pop_target_valid !== 1'b1 || pop_target !== 12'h0BB ||
        ckpt_count !== 4'd1 || ckpt_ptr !== 3'd1) begin
      errors++;
      $display("FAIL pp_empty got %0b/%h ptr %0d cnt %0d want 1/0bb 1 1",
               pop_target_valid, pop_target, ckpt_ptr, ckpt_count);
    end
  endtask

  task automatic test_restore;
    logic [2:0] sp;
    logic [3:0] sc;
    do_reset();
    drive(1'b1, 12'h010, 2'd1, 1'b0); tick();
    sp = ckpt_ptr;
    sc = ckpt_count;
    checks++;
    if (sp !== 3'd1 || sc !== 4'd1) begin
      errors++; $display("FAIL rst_ckpt got ptr %0d cnt %0d want 1 1", sp, sc);
    end
    drive(1'b1, 12'h020, 2'd2, 1'b0); tick();
    drive(1'b0, 12'h0, 2'd0, 1'b1); tick();
    drive(1'b0, 12'h0, 2'd0, 1'b1); tick();
    drive(1'b1, 12'h999, 2'd3, 1'b0);
    restore_valid = 1'b1;
    restore_ptr = 3'd1;
    restore_count = 4'd1;
    tick();
    checks++;
    if (pop_target !== 12'h010 || pop_upc_index !== 2'd1 ||
        ckpt_count !== 4'd1 || ckpt_ptr !== 3'd1 || pop_target_valid !== 1'b1) begin
      errors++;
      $display("FAIL restore got %h/%0d ptr %0d cnt %0d want 010/1 1 1",
               pop_target, pop_upc_index, ckpt_ptr, ckpt_count);
    end
    restore_valid = 1'b1;
    restore_ptr = 3'd3;
    restore_count = 4'd15;
    tick();
    checks++;
    if (ckpt_count !== 4'd8 || ckpt_ptr !== 3'd3) begin
      errors++;
      $display("FAIL restore_clamp got ptr %0d cnt %0d want 3 8",
               ckpt_ptr, ckpt_count);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 12'h100 + 12'(i), 2'd2, 1'b0); tick();
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if (pop_target_valid !== 1'b0 || ckpt_count !== 4'd0 ||
        ckpt_ptr !== 3'd0 || pop_target !== 12'h0 || pop_upc_index !== 2'd0) begin
      errors++;
      $display("FAIL async_clear got %0b/%h ptr %0d cnt %0d want 0/000 0 0",
               pop_target_valid, pop_target, ckpt_ptr, ckpt_count);
    end
    RST = 1'b0;
    drive(1'b1, 12'h7FF, 2'd3, 1'b0); tick();
    checks++;
    if (ckpt_ptr !== 3'd1 || ckpt_count !== 4'd1 ||
        pop_target !== 12'h7FF || pop_upc_index !== 2'd3) begin
      errors++;
      $display("FAIL async_after got %h/%0d ptr %0d cnt %0d want 7ff/3 1 1",
               pop_target, pop_upc_index, ckpt_ptr, ckpt_count);
    end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_overflow();
    test_push_pop();
    test_restore();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ras.md
# ras

Return address stack for the branch prediction front end. It predicts return targets by pushing the fall-through address on calls and popping it on returns. Each entry holds the low target bits plus an index into the upper-PC table, so the full target is rebuilt the same way as for BTB targets. It exposes a per-cycle checkpoint (pointer and count) that the front end attaches to each predicted branch, and it accepts a restore of that checkpoint on a mispredict.

## Interface
Parameters:
- RAS_DEPTH, 8: number of stack entries; must be a power of 2, ≥2.
- RAS_TARGET_WIDTH, 12: stored low target bits; equals BTB_TARGET_WIDTH.
- UPPER_PC_TABLE_ENTRIES, 4: size of the upper-PC table that is indexed.
- LOG_RAS_DEPTH, $clog2(RAS_DEPTH): derived.
- LOG_UPPER_PC_TABLE_ENTRIES, $clog2(UPPER_PC_TABLE_ENTRIES): derived.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; asynchronous, active-high.
- push_valid  in  1  a call was predicted this cycle.
- push_target  in  RAS_TARGET_WIDTH  low bits of the return address.
- push_upc_index  in  LOG_UPPER_PC_TABLE_ENTRIES  upper-PC table index for the return address.
- pop_valid  in  1  a return was predicted this cycle.
- pop_target_valid  out  1  the stack is non-empty, so pop_target is meaningful.
- pop_target  out  RAS_TARGET_WIDTH  low bits of the top entry.
- pop_upc_index  out  LOG_UPPER_PC_TABLE_ENTRIES  upper-PC index of the top entry.
- ckpt_ptr  out  LOG_RAS_DEPTH  current top pointer.
- ckpt_count  out  LOG_RAS_DEPTH+1  current valid-entry count, 0..RAS_DEPTH.
- restore_valid  in  1  mispredict recovery this cycle.
- restore_ptr  in  LOG_RAS_DEPTH  checkpointed pointer.
- restore_count  in  LOG_RAS_DEPTH+1  checkpointed count.

## Operation
- State: entry array, ptr (index of the top entry), count (saturating).
- Outputs are combinational from registered state and show the pre-update top:
  - pop_target and pop_upc_index = entry[ptr].
  - pop_target_valid = (count != 0).
  - ckpt_ptr = ptr; ckpt_count = count.
- Update priority, highest first: RST, then restore_valid, then push/pop.
- Restore:
  - ptr <= restore_ptr.
  - count <= min(restore_count, RAS_DEPTH).
  - Entries are not modified.
  - push_valid and pop_valid are ignored that cycle.
- Push only:
  - ptr <= ptr+1, modulo RAS_DEPTH.
  - entry[ptr+1] <= {push_upc_index, push_target}.
  - count <= min(count+1, RAS_DEPTH).
  - When full, the push silently overwrites the oldest entry (circular wrap).
- Pop only:
  - If count>0: ptr <= ptr-1 (modulo), count <= count-1.
  - If count==0: no state change, and pop_target_valid=0 is visible that cycle.
- Push and pop in the same cycle (e.g. jalr with rd=rs1=ra):
  - If count>0: entry[ptr] is overwritten with the push data; ptr and count are unchanged.
  - If count==0: behaves as push only.
- Neither push nor pop: hold all state.
- Entries past the valid region keep stale data. After a restore they are reused as-is; this is intentional, since the recovery accuracy is best-effort.

## Timing
- Prediction latency 0: the pop outputs are valid in the same cycle as pop_valid.
- State update takes effect at the next rising CLK; outputs reflect it from that cycle on.
- A checkpoint sampled in cycle N equals the state before cycle N's push/pop.
- Restoring that checkpoint makes the outputs equal to their cycle-N values in the cycle after restore_valid, provided no overwrite occurred.
- Reset (asynchronous, active-high):
  - ptr=0, count=0, all entries 0.
  - pop_target_valid=0, pop_target=0, pop_upc_index=0.
  - ckpt_ptr=0, ckpt_count=0.
  - Asserting RST mid-sequence clears state immediately, without waiting for a clock edge.
  - The first edge after RST deasserts processes inputs normally.
- Single-cycle handshake-free interface; no backpressure. The caller must qualify push_valid and pop_valid with fetch validity.

## Test plan
- Reset: hold RST for 2 cycles, then release. Expect pop_target_valid=0, ckpt_ptr=0, ckpt_count=0, pop_target=0.
- LIFO: push 0x111/idx1, 0x222/idx2, 0x333/idx3, then pop 3 times. Expect pops of 0x333/3, 0x222/2, 0x111/1, then pop_target_valid=0 and count=0. A 4th pop leaves ptr unchanged.
- Overflow: push 0x001..0x00A (10 pushes, DEPTH=8). Expect count=8 and ckpt_ptr=2. The next 8 pops return 0x00A down to 0x003, all valid; the 9th pop has pop_target_valid=0.
- Simultaneous push+pop:
  - Push 0x0AA, then push+pop with 0x0BB. Expect the pop output in that cycle to be 0x0AA; afterwards top=0x0BB and count=1.
  - Repeat from empty: expect count=1 and top=0x0BB.
- Restore: push 0x010, record ckpt (ptr=1, count=1), push 0x020, pop, pop. Then assert restore_valid with ptr=1, count=1, together with push_valid. Expect the push to be ignored, next-cycle top=0x010, count=1.
- Async reset mid-operation: after 5 pushes, assert RST between clock edges. Expect outputs to clear without a clock edge; after release, a push of 0x7FF gives ckpt_ptr=1, count=1, top=0x7FF.
